// File: rtl/ibex_ex_seq.sv
// Issues one operation at a time into the EX block, drives its enables and
// first-cycle strobe, and holds the result until writeback takes it.
module ibex_ex_seq #(
    parameter int unsigned TagW      = 5,
    parameter int unsigned MaxCycles = 40
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [1:0]      issue_kind_i,
    input  logic [TagW-1:0] issue_tag_i,
    input  logic            flush_i,
    output logic            alu_instr_first_cycle_o,
    output logic            mult_en_o,
    output logic            div_en_o,
    output logic            mult_sel_o,
    output logic            div_sel_o,
    output logic            multdiv_ready_id_o,
    input  logic            ex_valid_i,
    input  logic [31:0]     result_ex_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [31:0]     wb_result_o,
    output logic [TagW-1:0] wb_tag_o,
    output logic            busy_o,
    output logic            timeout_o,
    output logic [31:0]     busy_cycles_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [7:0] CntLast = 8'(MaxCycles - 1);
    localparam logic [1:0] KindMul = 2'b10;
    localparam logic [1:0] KindDiv = 2'b11;

    state_e          state_q;
    logic [1:0]      kind_q;
    logic [TagW-1:0] tag_q;
    logic [31:0]     result_q;
    logic [7:0]      cnt_q;
    logic [31:0]     busy_cycles_q;

    logic in_idle, in_exec, in_hold;
    logic accept, cnt_last, is_mul, is_div;

    assign in_idle  = (state_q == IDLE);
    assign in_exec  = (state_q == EXEC);
    assign in_hold  = (state_q == HOLD);
    assign cnt_last = (cnt_q == CntLast);
    assign is_mul   = (kind_q == KindMul);
    assign is_div   = (kind_q == KindDiv);

    // A new op may enter in the same cycle writeback drains the held one.
    assign issue_ready_o = ~flush_i & (in_idle | (in_hold & wb_ready_i));
    assign accept        = issue_valid_i & issue_ready_o;

    assign alu_instr_first_cycle_o = in_exec & (cnt_q == 8'd0);
    assign mult_en_o          = in_exec & is_mul & ~flush_i;
    assign div_en_o           = in_exec & is_div & ~flush_i;
    assign mult_sel_o         = in_exec & is_mul;
    assign div_sel_o          = in_exec & is_div;
    assign multdiv_ready_id_o = in_exec & ex_valid_i & ~flush_i;
    assign timeout_o          = in_exec & ~ex_valid_i & ~flush_i & cnt_last;

    assign wb_valid_o    = in_hold;
    assign wb_result_o   = in_hold ? result_q : 32'd0;
    assign wb_tag_o      = in_hold ? tag_q : '0;
    assign busy_o        = ~in_idle;
    assign busy_cycles_o = busy_cycles_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            kind_q        <= 2'b00;
            tag_q         <= '0;
            result_q      <= 32'd0;
            cnt_q         <= 8'd0;
            busy_cycles_q <= 32'd0;
        end else begin
            if (in_exec && (busy_cycles_q != 32'hFFFF_FFFF)) begin
                busy_cycles_q <= busy_cycles_q + 32'd1;
            end
            // Flush beats completion, watchdog and the writeback handshake.
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            state_q <= EXEC;
                            kind_q  <= issue_kind_i;
                            tag_q   <= issue_tag_i;
                            cnt_q   <= 8'd0;
                        end
                    end
                    EXEC: begin
                        if (ex_valid_i) begin
                            result_q <= result_ex_i;
                            state_q  <= HOLD;
                        end else if (cnt_last) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    HOLD: begin
                        if (wb_ready_i) begin
                            if (accept) begin
                                state_q <= EXEC;
                                kind_q  <= issue_kind_i;
                                tag_q   <= issue_tag_i;
                                cnt_q   <= 8'd0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ibex_ex_seq.sv
// Self-checking bench for ibex_ex_seq: vector table, directed corner cases,
// then random traffic against an operation-level reference model.
module tb_ibex_ex_seq;

    localparam int MAXC = 40;

    logic        clk_i, rst_i;
    logic        issue_valid_i, issue_ready_o;
    logic [1:0]  issue_kind_i;
    logic [4:0]  issue_tag_i;
    logic        flush_i;
    logic        alu_instr_first_cycle_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o;
    logic        multdiv_ready_id_o, ex_valid_i;
    logic [31:0] result_ex_i;
    logic        wb_valid_o, wb_ready_i;
    logic [31:0] wb_result_o;
    logic [4:0]  wb_tag_o;
    logic        busy_o, timeout_o;
    logic [31:0] busy_cycles_o;

    ibex_ex_seq #(.TagW(5), .MaxCycles(MAXC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_kind_i(issue_kind_i), .issue_tag_i(issue_tag_i),
        .flush_i(flush_i),
        .alu_instr_first_cycle_o(alu_instr_first_cycle_o),
        .mult_en_o(mult_en_o), .div_en_o(div_en_o),
        .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
        .multdiv_ready_id_o(multdiv_ready_id_o),
        .ex_valid_i(ex_valid_i), .result_ex_i(result_ex_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_result_o(wb_result_o), .wb_tag_o(wb_tag_o),
        .busy_o(busy_o), .timeout_o(timeout_o), .busy_cycles_o(busy_cycles_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation may be executing, one result may be held.
    bit          m_active, m_held;
    int          m_age;          // EXEC cycles already spent by the running op
    logic [1:0]  m_kind;
    logic [4:0]  m_tag, m_htag;
    logic [31:0] m_hres, m_busy;

    task automatic model_reset();
        m_active = 0; m_held = 0; m_age = 0; m_kind = 2'b00;
        m_tag = 5'd0; m_htag = 5'd0; m_hres = 32'd0; m_busy = 32'd0;
    endtask

    function automatic bit m_ready();
        return !flush_i && ((!m_active && !m_held) || (m_held && wb_ready_i));
    endfunction

    task automatic model_check();
        bit mul_op, div_op;
        mul_op = m_active && (m_kind == 2'b10);
        div_op = m_active && (m_kind == 2'b11);
        chk1("issue_ready", issue_ready_o, m_ready());
        chk1("first_cycle", alu_instr_first_cycle_o, m_active && (m_age == 0));
        chk1("mult_en", mult_en_o, mul_op && !flush_i);
        chk1("div_en", div_en_o, div_op && !flush_i);
        chk1("mult_sel", mult_sel_o, mul_op);
        chk1("div_sel", div_sel_o, div_op);
        chk1("md_ready", multdiv_ready_id_o, m_active && ex_valid_i && !flush_i);
        chk1("wb_valid", wb_valid_o, m_held);
        chk32("wb_result", wb_result_o, m_held ? m_hres : 32'd0);
        chk32("wb_tag", 32'(wb_tag_o), m_held ? 32'(m_htag) : 32'd0);
        chk1("busy", busy_o, m_active || m_held);
        chk1("timeout", timeout_o, m_active && !ex_valid_i && !flush_i && (m_age == MAXC - 1));
        chk32("busy_cycles", busy_cycles_o, m_busy);
    endtask

    task automatic model_update();
        bit acc;
        acc = issue_valid_i && m_ready();
        if (m_active && m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 32'd1;
        if (flush_i) begin
            m_active = 0;
            m_held   = 0;
        end else if (m_active) begin
            if (ex_valid_i) begin
                m_held = 1; m_hres = result_ex_i; m_htag = m_tag; m_active = 0;
            end else if (m_age + 1 == MAXC) begin
                m_active = 0;
            end else begin
                m_age++;
            end
        end else if (m_held && wb_ready_i) begin
            m_held = 0;
        end
        if (acc) begin
            m_active = 1; m_age = 0; m_kind = issue_kind_i; m_tag = issue_tag_i;
        end
    endtask

    // Called at posedge+2 or so; leaves time at posedge+1 of the next cycle.
    task automatic cycle();
        #1;
        model_check();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid_i = 0; issue_kind_i = 2'b00; issue_tag_i = 5'd0;
        flush_i = 0; ex_valid_i = 0; result_ex_i = 32'd0; wb_ready_i = 0;
    endtask

    typedef struct {
        logic iv; logic [1:0] kind; logic [4:0] tag;
        logic exv; logic [31:0] res; logic wbr;
        logic e_ready, e_first, e_mdr, e_wbv;
        logic [31:0] e_res; logic [4:0] e_tag; logic e_busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int div_cnt, first_cnt, to_cnt, to_at;
        bit wbv_seen, slow;

        vecs[0] = '{1'b1, 2'b01, 5'd3, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0};
        vecs[1] = '{1'b0, 2'b00, 5'd0, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 1'b1};
        vecs[2] = '{1'b0, 2'b00, 5'd0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 5'd3, 1'b1};
        vecs[3] = '{1'b1, 2'b00, 5'd1, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0};
        vecs[4] = '{1'b0, 2'b00, 5'd0, 1'b1, 32'h55,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 1'b1};
        vecs[5] = '{1'b1, 2'b00, 5'd2, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55,   5'd1, 1'b1};
        vecs[6] = '{1'b0, 2'b00, 5'd0, 1'b1, 32'h66,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 1'b1};
        vecs[7] = '{1'b0, 2'b00, 5'd0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h66,   5'd2, 1'b1};
        vecs[8] = '{1'b0, 2'b00, 5'd0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0};

        idle_inputs();
        rst_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        #1;
        chk1("rst_issue_ready", issue_ready_o, 1'b1);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_wb_valid", wb_valid_o, 1'b0);
        chk32("rst_wb_result", wb_result_o, 32'd0);
        chk32("rst_busy_cycles", busy_cycles_o, 32'd0);
        chk1("rst_timeout", timeout_o, 1'b0);
        cycle();

        // Vector table: single-cycle ALU ops, back-to-back through HOLD
        for (int i = 0; i < 9; i++) begin
            issue_valid_i = vecs[i].iv; issue_kind_i = vecs[i].kind; issue_tag_i = vecs[i].tag;
            ex_valid_i = vecs[i].exv; result_ex_i = vecs[i].res; wb_ready_i = vecs[i].wbr;
            flush_i = 1'b0;
            #1;
            chk1($sformatf("vec%0d_ready", i), issue_ready_o, vecs[i].e_ready);
            chk1($sformatf("vec%0d_first", i), alu_instr_first_cycle_o, vecs[i].e_first);
            chk1($sformatf("vec%0d_mdready", i), multdiv_ready_id_o, vecs[i].e_mdr);
            chk1($sformatf("vec%0d_wbvalid", i), wb_valid_o, vecs[i].e_wbv);
            chk32($sformatf("vec%0d_wbresult", i), wb_result_o, vecs[i].e_res);
            chk32($sformatf("vec%0d_wbtag", i), 32'(wb_tag_o), 32'(vecs[i].e_tag));
            chk1($sformatf("vec%0d_busy", i), busy_o, vecs[i].e_busy);
            cycle();
        end
        idle_inputs();

        // Clear busy counter with an async reset pulse while idle
        rst_i = 1'b1; #1 rst_i = 1'b0;
        model_reset();
        #1;

        // DIV taking 37 EXEC cycles
        issue_valid_i = 1; issue_kind_i = 2'b11; issue_tag_i = 5'd7;
        cycle();
        issue_valid_i = 0;
        div_cnt = 0; first_cnt = 0;
        for (int i = 1; i <= 37; i++) begin
            ex_valid_i = (i == 37); result_ex_i = 32'hDEAD_0037;
            #1;
            div_cnt += int'(div_en_o);
            first_cnt += int'(alu_instr_first_cycle_o);
            cycle();
        end
        ex_valid_i = 0; wb_ready_i = 0;
        chk32("div_en_cycles", 32'(div_cnt), 32'd37);
        chk32("div_first_cycles", 32'(first_cnt), 32'd1);
        #1;
        chk32("div_busy_cycles", busy_cycles_o, 32'd37);

        // HOLD stalled for 5 cycles, then handshake with a MUL issue
        for (int i = 0; i < 5; i++) begin
            if (i != 0) #1;
            chk32("hold_result", wb_result_o, 32'hDEAD_0037);
            chk32("hold_tag", 32'(wb_tag_o), 32'd7);
            cycle();
        end
        wb_ready_i = 1; issue_valid_i = 1; issue_kind_i = 2'b10; issue_tag_i = 5'd9;
        #1 chk1("hs_accept", issue_ready_o, 1'b1);
        cycle();
        issue_valid_i = 0; wb_ready_i = 0;

        // MUL that never completes: watchdog
        to_cnt = 0; to_at = 0; wbv_seen = 0;
        for (int i = 1; i <= 42; i++) begin
            #1;
            if (i == 1) chk1("mul_en_after_hs", mult_en_o, 1'b1);
            if (timeout_o) begin to_cnt++; to_at = i; end
            if (i == 41) chk1("busy_after_timeout", busy_o, 1'b0);
            if (i > 1) wbv_seen = wbv_seen | wb_valid_o;
            cycle();
        end
        chk32("timeout_pulses", 32'(to_cnt), 32'd1);
        chk32("timeout_exec_cycle", 32'(to_at), 32'(MAXC));
        chk1("timeout_no_wb", wbv_seen, 1'b0);

        // Flush coinciding with ex_valid in EXEC
        issue_valid_i = 1; issue_kind_i = 2'b01; issue_tag_i = 5'd4;
        cycle();
        flush_i = 1; ex_valid_i = 1; result_ex_i = 32'hBAD0_0001;
        #1;
        chk1("flush_md_ready", multdiv_ready_id_o, 1'b0);
        chk1("flush_issue_ready", issue_ready_o, 1'b0);
        cycle();
        idle_inputs();
        #1;
        chk1("flush_busy_next", busy_o, 1'b0);
        chk1("flush_no_wb", wb_valid_o, 1'b0);
        cycle();

        // Flush while holding a result
        issue_valid_i = 1; issue_kind_i = 2'b00; issue_tag_i = 5'd5;
        cycle();
        issue_valid_i = 0; ex_valid_i = 1; result_ex_i = 32'h0000_5A5A;
        cycle();
        ex_valid_i = 0; flush_i = 1; wb_ready_i = 1;
        #1 chk1("hold_flush_wbv_same", wb_valid_o, 1'b1);
        cycle();
        idle_inputs();
        #1 chk1("hold_flush_wbv_next", wb_valid_o, 1'b0);
        cycle();

        // Async reset in the middle of a DIV
        issue_valid_i = 1; issue_kind_i = 2'b11; issue_tag_i = 5'd2;
        cycle();
        issue_valid_i = 0;
        cycle();
        #1 chk1("pre_rst_div_en", div_en_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk1("arst_div_en", div_en_o, 1'b0);
        chk1("arst_busy", busy_o, 1'b0);
        chk1("arst_wb_valid", wb_valid_o, 1'b0);
        chk1("arst_issue_ready", issue_ready_o, 1'b1);
        chk32("arst_busy_cycles", busy_cycles_o, 32'd0);
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Random traffic; slow phases let the watchdog fire
        slow = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) slow = ($urandom_range(0, 2) == 0);
            issue_valid_i = ($urandom_range(0, 1) == 1);
            issue_kind_i  = 2'($urandom_range(0, 3));
            issue_tag_i   = 5'($urandom_range(0, 31));
            flush_i       = ($urandom_range(0, 15) == 0);
            ex_valid_i    = slow ? ($urandom_range(0, 60) == 0) : ($urandom_range(0, 2) == 0);
            result_ex_i   = $urandom;
            wb_ready_i    = ($urandom_range(0, 1) == 1);
            #1;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
